// File: rtl/divider_n.sv
// Multi-cycle restoring divider (IDLE -> CALC -> FIX -> DONE), one quotient bit per cycle.
// Signed operation is compiled in only when DIVIDER_N_SIGNED_EN is defined; otherwise sgn is ignored.
module divider_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             busy_nxt;
  logic             done_nxt;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

`ifdef DIVIDER_N_SIGNED_EN
  assign signed_op = sgn;
`else
  // sgn is tied off but still referenced so the port is not flagged as unused.
  assign signed_op = sgn & 1'b0;
`endif

  assign a_neg  = signed_op & A[WIDTH-1];
  assign b_neg  = signed_op & B[WIDTH-1];
  assign a_mag  = a_neg ? ({WIDTH{1'b0}} - A) : A;
  assign b_mag  = b_neg ? ({WIDTH{1'b0}} - B) : B;
  assign b_zero = (B == {WIDTH{1'b0}});

  // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  // A set shifted[WIDTH] always exceeds dvs, so the subtraction cannot borrow in that case.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = b_zero ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          state_nxt = FIX;
        end else begin
          state_nxt = CALC;
        end
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: done trails the DONE state by one edge so Q/R are already stable when it rises
  always_comb begin
    busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
    done_nxt = (state == DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      Q     <= {WIDTH{1'b0}};
      R     <= {WIDTH{1'b0}};
      cnt   <= {CW{1'b0}};
      quo   <= {WIDTH{1'b0}};
      rem   <= {WIDTH{1'b0}};
      dvs   <= {WIDTH{1'b0}};
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            err <= b_zero;
            if (b_zero) begin
              Q <= {WIDTH{1'b1}};
              R <= A;
            end else begin
              quo   <= a_mag;
              rem   <= {WIDTH{1'b0}};
              dvs   <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          // Truncation toward zero: quotient sign from operand signs, remainder follows dividend.
          Q <= neg_q ? ({WIDTH{1'b0}} - quo) : quo;
          R <= neg_r ? ({WIDTH{1'b0}} - rem) : rem;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/divider_n.md
DIVIDER_N -- requirements
Module: divider_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand, quotient and remainder width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port sgn  input  1  1 = signed (two's complement) operation, 0 = unsigned; sampled with start.
REQ-006 SHALL have port A  input  WIDTH  dividend; captured on the edge that accepts start.
REQ-007 SHALL have port B  input  WIDTH  divisor; captured on the edge that accepts start.
REQ-008 SHALL have port busy  output  1  high from the edge after acceptance until the edge that enters DONE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  divide-by-zero flag for the last operation.
REQ-011 SHALL have port Q  output  WIDTH  quotient, registered.
REQ-012 SHALL have port R  output  WIDTH  remainder, registered.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE: IDLE->CALC on start with B!=0; IDLE->DONE on start with B==0; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 SHALL perform restoring division on operand magnitudes, one quotient bit per CALC cycle, with a WIDTH-bit iteration counter loaded on acceptance.
REQ-015 SHALL apply sign correction in FIX: quotient negated when operand signs differ, remainder given the dividend's sign (truncation toward zero); FIX is a pass-through cycle when sgn=0.
REQ-016 SHALL raise done WIDTH+2 edges after the accepting edge for B!=0, and 1 edge after for B==0; done high for exactly one cycle.
REQ-017 SHALL, for B==0, set err=1, Q=all ones, R=A captured.
REQ-018 SHALL clear err on the edge accepting the next start; err, Q, R SHALL hold between done and next acceptance.
REQ-019 SHALL ignore start while not in IDLE (including in DONE); operands SHALL NOT be re-captured.
REQ-020 SHALL, for signed most-negative / -1, produce Q=most-negative value (wrap), R=0, err=0.
REQ-021 SHALL keep Q and R unchanged during CALC/FIX; they update on the edge entering DONE.

Reset
REQ-022 SHALL, while rst is high at a rising edge, force state IDLE, busy=0, done=0, err=0, Q=0, R=0, counter=0; rst dominates start.
REQ-023 SHALL abort any operation on rst mid-CALC/FIX with no done pulse; the next start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 SHALL honour macro DIVIDER_N_SIGNED_EN: when defined, signed mode per REQ-015/REQ-020 is compiled in; when undefined, sgn is ignored, all operations are unsigned, and FIX is still traversed so latency is unchanged.

Verification
REQ-025 SHALL verify WIDTH=8, unsigned, A=100, B=7 -> Q=14, R=2, err=0, done 10 edges after acceptance, busy high 9 cycles.
REQ-026 SHALL verify WIDTH=8, A=37, B=0 -> err=1, Q=0xFF, R=0x25, done 1 edge after acceptance; next start (A=9, B=3) -> err=0, Q=3, R=0.
REQ-027 SHALL verify WIDTH=8 with DIVIDER_N_SIGNED_EN, sgn=1: A=0xF9 (-7), B=2 -> Q=0xFD (-3), R=0xFF (-1); A=0x80, B=0xFF -> Q=0x80, R=0, err=0; same A=0xF9, B=2 without the macro -> Q=124, R=1.
REQ-028 SHALL verify start pulsed during CALC with different operands is ignored -> first result unchanged, exactly one done pulse.
REQ-029 SHALL verify rst asserted in 4th CALC cycle -> all outputs 0 on the next edge, no done; subsequent A=200, B=13 -> Q=15, R=5.
REQ-030 SHALL verify WIDTH=16, A=65535, B=255 -> Q=257, R=0, done 18 edges after acceptance.
